// File: rtl/ctrl_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ctrl_pkg : opcodes, control enums and stage bundles for ctrl_pipe       |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int CTRL_AW = 5;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    SRCA_RS1  = 2'b00,
    SRCA_PC   = 2'b01,
    SRCA_ZERO = 2'b10
  } alu_src_a_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_ctrl_e;

  typedef struct packed {
    logic                 reg_write;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic                 jalr;
    alu_src_a_e           alu_src_a;
    logic                 alu_src_b;
    alu_ctrl_e            alu_ctrl;
    logic [2:0]           funct3;
    result_src_e          result_src;
    logic [CTRL_AW-1:0]   rs1;
    logic [CTRL_AW-1:0]   rs2;
    logic [CTRL_AW-1:0]   rd;
  } ctrl_t;

  // Later stages only need what memory access and writeback consume.
  typedef struct packed {
    logic                 reg_write;
    logic                 mem_write;
    result_src_e          result_src;
    logic [CTRL_AW-1:0]   rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic                 reg_write;
    result_src_e          result_src;
    logic [CTRL_AW-1:0]   rd;
  } wb_ctrl_t;

  localparam ctrl_t     CTRL_BUBBLE = '0;
  localparam mem_ctrl_t MEM_BUBBLE  = '0;

  // alt is funct7[5]; callers gate it for the I-ALU case.
  function automatic alu_ctrl_e alu_op(input logic [2:0] f3, input logic alt);
    alu_op = ALU_ADD;
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_pipe_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ctrl_pipe_if : decode inputs and staged control outputs of ctrl_pipe    |
// | Revision     : 1.0                                                      |
// +-------------------------------------------------------------------------+
interface ctrl_pipe_if #(
  parameter int IMMSRC_W    = 3,
  parameter int RESULTSRC_W = 2,
  parameter int ALUCTRL_W   = 4,
  parameter int REG_AW      = 5
);
  logic [31:0]           InstrD;
  logic                  StallE;
  logic                  FlushE;
  logic                  FlushM;
  logic [IMMSRC_W-1:0]   ImmSrcD;
  logic [REG_AW-1:0]     Rs1D;
  logic [REG_AW-1:0]     Rs2D;
  logic                  IllegalD;
  logic                  RegWriteE;
  logic                  MemWriteE;
  logic                  JumpE;
  logic                  BranchE;
  logic                  JalrE;
  logic [1:0]            ALUSrcAE;
  logic                  ALUSrcBE;
  logic [ALUCTRL_W-1:0]  ALUControlE;
  logic [2:0]            Funct3E;
  logic [RESULTSRC_W-1:0] ResultSrcE;
  logic [REG_AW-1:0]     Rs1E;
  logic [REG_AW-1:0]     Rs2E;
  logic [REG_AW-1:0]     RdE;
  logic                  RegWriteM;
  logic                  MemWriteM;
  logic [RESULTSRC_W-1:0] ResultSrcM;
  logic [REG_AW-1:0]     RdM;
  logic                  RegWriteW;
  logic [RESULTSRC_W-1:0] ResultSrcW;
  logic [REG_AW-1:0]     RdW;
  logic                  IllegalW;

  modport master (
    output InstrD, StallE, FlushE, FlushM,
    input  ImmSrcD, Rs1D, Rs2D, IllegalD,
    input  RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcAE, ALUSrcBE,
    input  ALUControlE, Funct3E, ResultSrcE, Rs1E, Rs2E, RdE,
    input  RegWriteM, MemWriteM, ResultSrcM, RdM,
    input  RegWriteW, ResultSrcW, RdW, IllegalW
  );

  modport slave (
    input  InstrD, StallE, FlushE, FlushM,
    output ImmSrcD, Rs1D, Rs2D, IllegalD,
    output RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcAE, ALUSrcBE,
    output ALUControlE, Funct3E, ResultSrcE, Rs1E, Rs2E, RdE,
    output RegWriteM, MemWriteM, ResultSrcM, RdM,
    output RegWriteW, ResultSrcW, RdW, IllegalW
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ctrl_decode : combinational RV32I opcode/funct to control bundle        |
// | Revision    : 1.0                                                       |
// +-------------------------------------------------------------------------+
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output imm_src_e    imm_src,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  ctrl_t      c;
  imm_src_e   imm;
  logic       legal;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    c        = CTRL_BUBBLE;
    imm      = IMM_I;
    legal    = 1'b1;
    c.rs1    = instr[19:15];
    c.rs2    = instr[24:20];
    c.rd     = instr[11:7];
    c.funct3 = f3;
    case (opcode)
      OP_LOAD: begin
        legal        = (f3 == 3'b010);
        c.reg_write  = 1'b1;
        c.alu_src_b  = 1'b1;
        c.result_src = RES_MEM;
      end
      OP_STORE: begin
        legal       = (f3 == 3'b010);
        c.mem_write = 1'b1;
        c.alu_src_b = 1'b1;
        imm         = IMM_S;
      end
      OP_RTYPE: begin
        legal       = (f7 == 7'b0000000) ||
                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        c.reg_write = 1'b1;
        c.alu_ctrl  = alu_op(f3, f7[5]);
      end
      OP_IALU: begin
        // Only the shift encodings constrain the upper immediate bits.
        if (f3 == 3'b001)
          legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101)
          legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        c.reg_write = 1'b1;
        c.alu_src_b = 1'b1;
        c.alu_ctrl  = alu_op(f3, (f3 == 3'b101) && f7[5]);
      end
      OP_BRANCH: begin
        legal      = (f3 != 3'b010) && (f3 != 3'b011);
        c.branch   = 1'b1;
        c.alu_ctrl = ALU_SUB;
        imm        = IMM_B;
      end
      OP_JAL: begin
        c.jump       = 1'b1;
        c.reg_write  = 1'b1;
        c.result_src = RES_PC4;
        imm          = IMM_J;
      end
      OP_JALR: begin
        legal        = (f3 == 3'b000);
        c.jalr       = 1'b1;
        c.reg_write  = 1'b1;
        c.result_src = RES_PC4;
        c.alu_src_b  = 1'b1;
      end
      OP_LUI: begin
        c.reg_write = 1'b1;
        c.alu_src_a = SRCA_ZERO;
        c.alu_src_b = 1'b1;
        imm         = IMM_U;
      end
      OP_AUIPC: begin
        c.reg_write = 1'b1;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = 1'b1;
        imm         = IMM_U;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      c     = CTRL_BUBBLE;
      c.rs1 = instr[19:15];
      c.rs2 = instr[24:20];
      imm   = IMM_I;
    end
    // A non-writing bundle must never hit a forwarding compare.
    if (!c.reg_write)
      c.rd = '0;
  end

  assign ctrl    = c;
  assign imm_src = imm;
  assign illegal = ~legal;

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ctrl_pipe : D-stage decode plus ID/EX, EX/MEM, MEM/WB control registers |
// | Option    : CTRL_PIPE_ILLEGAL_TRAP_EN carries illegal to a sticky W flag |
// | Revision  : 1.0                                                         |
// +-------------------------------------------------------------------------+
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int IMMSRC_W    = 3,
  parameter int RESULTSRC_W = 2,
  parameter int ALUCTRL_W   = 4,
  parameter int REG_AW      = 5
) (
  input  logic         clk,
  input  logic         reset,
  ctrl_pipe_if.slave   bus
);

  ctrl_t     dec_ctrl;
  imm_src_e  dec_imm;
  logic      dec_illegal;

  ctrl_t     e_d, e_q;
  mem_ctrl_t m_d, m_q;
  wb_ctrl_t  w_d, w_q;

  ctrl_decode u_decode (
    .instr   (bus.InstrD),
    .ctrl    (dec_ctrl),
    .imm_src (dec_imm),
    .illegal (dec_illegal)
  );

  always_comb begin
    e_d = e_q;
    if (bus.FlushE)
      e_d = CTRL_BUBBLE;
    else if (!bus.StallE)
      e_d = dec_ctrl;

    m_d = MEM_BUBBLE;
    if (!bus.FlushM)
      m_d = '{reg_write: e_q.reg_write, mem_write: e_q.mem_write,
              result_src: e_q.result_src, rd: e_q.rd};

    w_d = '{reg_write: m_q.reg_write, result_src: m_q.result_src, rd: m_q.rd};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= CTRL_BUBBLE;
      m_q <= MEM_BUBBLE;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

`ifdef CTRL_PIPE_ILLEGAL_TRAP_EN
  logic ill_e_d, ill_e_q;
  logic ill_m_d, ill_m_q;
  logic ill_w_d, ill_w_q;

  always_comb begin
    ill_e_d = ill_e_q;
    if (bus.FlushE)
      ill_e_d = 1'b0;
    else if (!bus.StallE)
      ill_e_d = dec_illegal;
    ill_m_d = bus.FlushM ? 1'b0 : ill_e_q;
    // Sticky: sets as the illegal bundle lands in W.
    ill_w_d = ill_w_q | ill_m_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ill_e_q <= 1'b0;
      ill_m_q <= 1'b0;
      ill_w_q <= 1'b0;
    end else begin
      ill_e_q <= ill_e_d;
      ill_m_q <= ill_m_d;
      ill_w_q <= ill_w_d;
    end
  end

  assign bus.IllegalW = ill_w_q;
`else
  assign bus.IllegalW = 1'b0;
`endif

  assign bus.ImmSrcD     = IMMSRC_W'(dec_imm);
  assign bus.Rs1D        = REG_AW'(dec_ctrl.rs1);
  assign bus.Rs2D        = REG_AW'(dec_ctrl.rs2);
  assign bus.IllegalD    = dec_illegal;

  assign bus.RegWriteE   = e_q.reg_write;
  assign bus.MemWriteE   = e_q.mem_write;
  assign bus.JumpE       = e_q.jump;
  assign bus.BranchE     = e_q.branch;
  assign bus.JalrE       = e_q.jalr;
  assign bus.ALUSrcAE    = e_q.alu_src_a;
  assign bus.ALUSrcBE    = e_q.alu_src_b;
  assign bus.ALUControlE = ALUCTRL_W'(e_q.alu_ctrl);
  assign bus.Funct3E     = e_q.funct3;
  assign bus.ResultSrcE  = RESULTSRC_W'(e_q.result_src);
  assign bus.Rs1E        = REG_AW'(e_q.rs1);
  assign bus.Rs2E        = REG_AW'(e_q.rs2);
  assign bus.RdE         = REG_AW'(e_q.rd);

  assign bus.RegWriteM   = m_q.reg_write;
  assign bus.MemWriteM   = m_q.mem_write;
  assign bus.ResultSrcM  = RESULTSRC_W'(m_q.result_src);
  assign bus.RdM         = REG_AW'(m_q.rd);

  assign bus.RegWriteW   = w_q.reg_write;
  assign bus.ResultSrcW  = RESULTSRC_W'(w_q.result_src);
  assign bus.RdW         = REG_AW'(w_q.rd);

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_ctrl_pipe : directed stimulus with queued expectations for ctrl_pipe |
// | Revision     : 1.0                                                      |
// +-------------------------------------------------------------------------+
module tb_ctrl_pipe;

  typedef struct packed {
    logic       rw, mw, j, b, jr;
    logic [1:0] a;
    logic       bs;
    logic [3:0] alu;
    logic [2:0] f3;
    logic [1:0] rs;
    logic [4:0] rs1, rs2, rd;
  } ex_t;

  typedef struct packed { logic rw, mw; logic [1:0] rs; logic [4:0] rd; } mx_t;
  typedef struct packed { logic rw; logic [1:0] rs; logic [4:0] rd; } wx_t;

  typedef struct { ex_t e; mx_t m; wx_t w; logic illw; } pexp_t;
  typedef struct { logic [2:0] imm; logic ill; logic [4:0] rs1, rs2; logic chk_zero; } dexp_t;

  pexp_t pq[$];
  dexp_t dq[$];

  int checks = 0;
  int errors = 0;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ctrl_pipe_if bus ();

  ctrl_pipe u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ex_t mk(input logic rw, mw, j, b, jr, input logic [1:0] a,
                             input logic bs, input logic [3:0] alu, input logic [2:0] f3,
                             input logic [1:0] rs, input logic [4:0] r1, r2, rd);
    ex_t e;
    e = '{rw, mw, j, b, jr, a, bs, alu, f3, rs, r1, r2, rd};
    return e;
  endfunction

  function automatic ex_t act_e();
    ex_t e;
    e = '{bus.RegWriteE, bus.MemWriteE, bus.JumpE, bus.BranchE, bus.JalrE, bus.ALUSrcAE,
          bus.ALUSrcBE, bus.ALUControlE, bus.Funct3E, bus.ResultSrcE, bus.Rs1E, bus.Rs2E, bus.RdE};
    return e;
  endfunction

  function automatic logic [49:0] act_all();
    mx_t m;
    wx_t w;
    m = '{bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RdM};
    w = '{bus.RegWriteW, bus.ResultSrcW, bus.RdW};
    return {act_e(), m, w, bus.IllegalW};
  endfunction

  // Reference pipeline state, advanced once per issued cycle.
  ex_t  m_e = '0;
  mx_t  m_m = '0;
  wx_t  m_w = '0;
  logic ill_e = 1'b0, ill_m = 1'b0, sticky = 1'b0;

  task automatic drive(input logic [31:0] ins, input ex_t de, input logic [2:0] imm,
                       input logic ill, input logic st, input logic fe, input logic fm,
                       input logic rn);
    @(negedge clk);
    reset      = rn;
    bus.InstrD = ins;
    bus.StallE = st;
    bus.FlushE = fe;
    bus.FlushM = fm;
    dq.push_back('{imm, ill, de.rs1, de.rs2, !rn});
    if (!rn) begin
      m_e = '0; m_m = '0; m_w = '0;
      ill_e = 1'b0; ill_m = 1'b0; sticky = 1'b0;
    end else begin
      m_w = '{m_m.rw, m_m.rs, m_m.rd};
`ifdef CTRL_PIPE_ILLEGAL_TRAP_EN
      if (ill_m) sticky = 1'b1;
`endif
      m_m   = fm ? mx_t'(0) : mx_t'({m_e.rw, m_e.mw, m_e.rs, m_e.rd});
      ill_m = fm ? 1'b0 : ill_e;
      if (fe) begin
        m_e = '0; ill_e = 1'b0;
      end else if (!st) begin
        m_e = de; ill_e = ill;
      end
    end
    pq.push_back('{m_e, m_m, m_w, sticky});
  endtask

  // D-stage monitor: combinational outputs, plus async-reset clearing.
  initial begin
    dexp_t d;
    forever begin
      @(negedge clk);
      #2;
      if (dq.size() > 0) begin
        d = dq.pop_front();
        chk("ImmSrcD",  64'(bus.ImmSrcD),  64'(d.imm));
        chk("IllegalD", 64'(bus.IllegalD), 64'(d.ill));
        chk("Rs1D",     64'(bus.Rs1D),     64'(d.rs1));
        chk("Rs2D",     64'(bus.Rs2D),     64'(d.rs2));
        if (d.chk_zero)
          chk("async_reset_clear", 64'(act_all()), 64'd0);
      end
    end
  end

  // Stage monitor: registered outputs after each rising edge.
  initial begin
    pexp_t p;
    forever begin
      @(posedge clk);
      #1;
      if (pq.size() > 0) begin
        p = pq.pop_front();
        chk("E_bundle", 64'(act_e()), 64'(p.e));
        chk("M_bundle", 64'({bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RdM}), 64'(p.m));
        chk("W_bundle", 64'({bus.RegWriteW, bus.ResultSrcW, bus.RdW}), 64'(p.w));
        chk("IllegalW", 64'(bus.IllegalW), 64'(p.illw));
      end
    end
  end

  localparam logic [31:0] I_NOP   = 32'h00000013;
  localparam logic [31:0] I_ADDI  = 32'h00A00093;
  localparam logic [31:0] I_LW    = 32'h0000A103;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_SRAI  = 32'h4030D213;
  localparam logic [31:0] I_ADDIN = 32'hC0000313;
  localparam logic [31:0] I_JAL   = 32'h010000EF;
  localparam logic [31:0] I_JALR  = 32'h00008067;
  localparam logic [31:0] I_AUIPC = 32'h00001397;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_ILL   = 32'h0000007F;
  localparam logic [31:0] I_ILLB  = 32'h00002063;

  ex_t x_nop, x_addi, x_lw, x_lui, x_sw, x_sub, x_srai, x_addin;
  ex_t x_jal, x_jalr, x_auipc, x_beq, x_zero;

  initial begin
    x_nop   = mk(1,0,0,0,0, 2'd0, 1, 4'd0, 3'd0, 2'd0, 5'd0, 5'd0,  5'd0);
    x_addi  = mk(1,0,0,0,0, 2'd0, 1, 4'd0, 3'd0, 2'd0, 5'd0, 5'd10, 5'd1);
    x_lw    = mk(1,0,0,0,0, 2'd0, 1, 4'd0, 3'd2, 2'd1, 5'd1, 5'd0,  5'd2);
    x_lui   = mk(1,0,0,0,0, 2'd2, 1, 4'd0, 3'd5, 2'd0, 5'd8, 5'd3,  5'd5);
    x_sw    = mk(0,1,0,0,0, 2'd0, 1, 4'd0, 3'd2, 2'd0, 5'd1, 5'd2,  5'd0);
    x_sub   = mk(1,0,0,0,0, 2'd0, 0, 4'd1, 3'd0, 2'd0, 5'd1, 5'd2,  5'd3);
    x_srai  = mk(1,0,0,0,0, 2'd0, 1, 4'd9, 3'd5, 2'd0, 5'd1, 5'd3,  5'd4);
    x_addin = mk(1,0,0,0,0, 2'd0, 1, 4'd0, 3'd0, 2'd0, 5'd0, 5'd0,  5'd6);
    x_jal   = mk(1,0,1,0,0, 2'd0, 0, 4'd0, 3'd0, 2'd2, 5'd0, 5'd16, 5'd1);
    x_jalr  = mk(1,0,0,0,1, 2'd0, 1, 4'd0, 3'd0, 2'd2, 5'd1, 5'd0,  5'd0);
    x_auipc = mk(1,0,0,0,0, 2'd1, 1, 4'd0, 3'd1, 2'd0, 5'd0, 5'd0,  5'd7);
    x_beq   = mk(0,0,0,1,0, 2'd0, 0, 4'd1, 3'd0, 2'd0, 5'd1, 5'd2,  5'd0);
    x_zero  = '0;

    bus.InstrD = I_NOP;
    bus.StallE = 1'b0;
    bus.FlushE = 1'b0;
    bus.FlushM = 1'b0;
    #7;
    chk("reset_state", 64'(act_all()), 64'd0);

    drive(I_NOP,   x_nop,   3'd0, 0, 0, 0, 0, 0);
    drive(I_NOP,   x_nop,   3'd0, 0, 0, 0, 0, 0);
    drive(I_ADDI,  x_addi,  3'd0, 0, 0, 0, 0, 1);
    drive(I_LW,    x_lw,    3'd0, 0, 0, 0, 0, 1);
    drive(I_LUI,   x_lui,   3'd4, 0, 0, 0, 0, 1);
    drive(I_SW,    x_sw,    3'd1, 0, 0, 0, 0, 1);
    drive(I_SUB,   x_sub,   3'd0, 0, 0, 0, 0, 1);
    drive(I_SRAI,  x_srai,  3'd0, 0, 0, 0, 0, 1);
    drive(I_ADDIN, x_addin, 3'd0, 0, 0, 0, 0, 1);
    drive(I_JAL,   x_jal,   3'd3, 0, 0, 0, 0, 1);
    drive(I_JALR,  x_jalr,  3'd0, 0, 0, 0, 0, 1);
    drive(I_AUIPC, x_auipc, 3'd4, 0, 0, 0, 0, 1);
    // Stall holds beq in E, then flush+stall bubbles it.
    drive(I_BEQ,   x_beq,   3'd2, 0, 0, 0, 0, 1);
    drive(I_ADDI,  x_addi,  3'd0, 0, 1, 0, 0, 1);
    drive(I_ADDI,  x_addi,  3'd0, 0, 1, 0, 0, 1);
    drive(I_ADDI,  x_addi,  3'd0, 0, 1, 1, 0, 1);
    drive(I_ADDI,  x_addi,  3'd0, 0, 0, 0, 0, 1);
    drive(I_NOP,   x_nop,   3'd0, 0, 0, 0, 1, 1);
    drive(I_NOP,   x_nop,   3'd0, 0, 0, 0, 0, 1);
    // Flushed illegal must not set the trap flag.
    drive(I_ILL,   x_zero,  3'd0, 1, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) drive(I_NOP, x_nop, 3'd0, 0, 0, 0, 0, 1);
    drive(I_ILLB,  x_zero,  3'd0, 1, 0, 0, 0, 1);
    drive(I_ILL,   x_zero,  3'd0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(I_NOP, x_nop, 3'd0, 0, 0, 0, 0, 1);
    // Four in flight, then reset asserted between edges.
    drive(I_ADDI,  x_addi,  3'd0, 0, 0, 0, 0, 1);
    drive(I_LW,    x_lw,    3'd0, 0, 0, 0, 0, 1);
    drive(I_SUB,   x_sub,   3'd0, 0, 0, 0, 0, 1);
    drive(I_LUI,   x_lui,   3'd4, 0, 0, 0, 0, 1);
    drive(I_JAL,   x_jal,   3'd3, 0, 0, 0, 0, 0);
    drive(I_ADDI,  x_addi,  3'd0, 0, 0, 0, 0, 1);
    drive(I_LW,    x_lw,    3'd0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(I_NOP, x_nop, 3'd0, 0, 0, 0, 0, 1);

    @(posedge clk);
    #3;
    chk("pq_drained", 64'(pq.size()), 64'd0);
    chk("dq_drained", 64'(dq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Parametrised successor to the single-cycle main decoder for the hazard-aware 5-stage RV32I core.
- Decodes the D-stage instruction into a full control bundle, including ALU decode, and carries it through the ID/EX, EX/MEM and MEM/WB registers with stall/flush.
- Also carries register addresses so the hazard unit and forwarding muxes have one source of truth.
- Adds lui, auipc, jalr and all B-type conditions.
- Flags illegal opcodes.

Parameters:
- IMMSRC_W, 3, width of immediate-select code (I/S/B/J/U)
- RESULTSRC_W, 2, width of writeback-select code
- ALUCTRL_W, 4, width of ALU operation code
- REG_AW, 5, register address width

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all pipeline registers immediately
- InstrD  in  32  instruction in Decode
- StallE  in  1  hold ID/EX register
- FlushE  in  1  bubble ID/EX register
- FlushM  in  1  bubble EX/MEM register
- ImmSrcD  out  IMMSRC_W  immediate select for D-stage extender (combinational)
- Rs1D, Rs2D  out  REG_AW each  source addresses (combinational, for load-use check)
- RegWriteE, MemWriteE, JumpE, BranchE, JalrE  out  1 each  E-stage controls
- ALUSrcAE  out  2  00 rs1, 01 PC, 10 zero
- ALUSrcBE  out  1  0 rs2, 1 imm
- ALUControlE  out  ALUCTRL_W  ALU operation
- Funct3E  out  3  branch condition select
- ResultSrcE  out  RESULTSRC_W  for load-use detect
- Rs1E, Rs2E, RdE  out  REG_AW each
- RegWriteM, MemWriteM  out  1 each
- ResultSrcM  out  RESULTSRC_W
- RdM  out  REG_AW
- RegWriteW  out  1
- ResultSrcW  out  RESULTSRC_W
- RdW  out  REG_AW
- IllegalD  out  1  opcode/funct not recognised (combinational)
- IllegalW  out  1  see Optional Feature

Behaviour:
- Decode is combinational on InstrD. Opcodes: 0000011 lw, 0100011 sw, 0110011 R, 0010011 I-ALU, 1100011 branch, 1101111 jal, 1100111 jalr, 0110111 lui, 0010111 auipc.
- ResultSrc: 00 ALU, 01 memory, 10 PC+4.
- ImmSrc: 000 I, 001 S, 010 B, 011 J, 100 U.
- lui: ALUSrcA=10, ALUSrcB=1, add.
- auipc: ALUSrcA=01, ALUSrcB=1, add.
- jalr: RegWrite=1, ResultSrc=10, ALUSrcB=1, add, Jalr=1, Jump=0.
- jal: Jump=1, ResultSrc=10, RegWrite=1.
- Branch: Branch=1, ALU sub, Funct3 passed through. funct3 010/011 are illegal for branches.
- R-type: funct7 bit5 selects sub/sra. I-ALU: funct7 bit5 applies only to srai.
- Illegal or unknown opcode: every control 0 (RegWrite, MemWrite, Branch, Jump, Jalr all 0), IllegalD=1.
- Rd is forced to 0 whenever RegWrite=0, so a bubble never matches a forwarding compare.
- Latency: the D bundle appears on E outputs 1 cycle later, M 2 cycles, W 3 cycles.
- Priority at ID/EX: reset > FlushE > StallE > load. FlushE and StallE together produce a bubble.
- EX/MEM: FlushM loads a bubble, otherwise loads from E. It is never stalled.
- MEM/WB: always loads from M.
- Bubble = all controls 0, all addresses 0, Illegal 0.
- reset low, even mid-operation: every registered output goes to 0 asynchronously. The first valid bundle reaches E on the first rising edge after release.

Optional Feature:
- Macro CTRL_PIPE_ILLEGAL_TRAP_EN.
- Defined: the illegal bit is carried E→M→W. IllegalW is a sticky flag, set the cycle an illegal bundle reaches W and cleared only by reset. A flushed illegal instruction never sets it.
- Undefined: IllegalW is tied to 0 and no illegal bits are registered. IllegalD still works.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams
  - enums for ResultSrc, ImmSrc, ALUSrcA and ALUControl (0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra)
  - packed struct ctrl_t for the bundle, plus a CTRL_BUBBLE constant
- Natural sub-module: ctrl_decode, the combinational opcode/funct → ctrl_t decoder. It replaces the separate main and ALU decoders.
- ctrl_pipe instantiates ctrl_decode and holds the three stage registers.

Test Plan:
- addi x1,x0,10 (0x00A00093): cycle+1 RegWriteE=1, ALUSrcBE=1, ALUControlE=0000, RdE=1; cycle+3 RegWriteW=1, RdW=1, ResultSrcW=00.
- lw x2,0(x1) (0x0000A103): ResultSrcE=01, RegWriteE=1, RdE=2; ResultSrcM=01 the following cycle.
- lui x5,0x12345 (0x123452B7): ImmSrcD=100; next cycle ALUSrcAE=10, ALUSrcBE=1, RdE=5.
- beq then StallE=1 for 2 cycles: E outputs hold BranchE=1, Funct3E=000, RdE=0. Then FlushE=1 with StallE=1: all E outputs 0.
- 0x0000007F: IllegalD=1, all controls 0. With macro, IllegalW=1 three cycles later and stays 1. With FlushE on that cycle, IllegalW stays 0.
- reset low mid-stream with four instructions in flight: all E/M/W outputs 0 within the same cycle. Normal flow resumes after release.
